// File: rtl/keyword_skid_pkg.sv
// Shared types and default sizing for the keyword-port skid slice.
package keyword_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } slice_state_e;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_COUNT_W  = 16;

endpackage

// File: rtl/keyword_skid_slice_if.sv
// Vectored multi-channel handshake bundle between a generated wrapper and its core.
interface keyword_skid_slice_if
  import keyword_skid_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int COUNT_W  = DEF_COUNT_W
) ();

  logic                        always_enable;
  logic [CHANNELS-1:0]         module_select;
  logic [CHANNELS-1:0]         input_valid;
  logic [CHANNELS-1:0]         input_ready;
  logic [CHANNELS*WIDTH-1:0]   input_data;
  logic [CHANNELS-1:0]         output_valid;
  logic [CHANNELS-1:0]         output_ready;
  logic [CHANNELS*WIDTH-1:0]   output_data;
  logic [CHANNELS*COUNT_W-1:0] reg_count;
  logic                        endmodule_flag;

  modport master (
    output always_enable, module_select, input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_data, reg_count, endmodule_flag
  );

  modport slave (
    input  always_enable, module_select, input_valid, input_data, output_ready,
    output input_ready, output_valid, output_data, reg_count, endmodule_flag
  );

endinterface

// File: rtl/keyword_skid_chan.sv
// One channel: 2-entry skid buffer with valid/ready on both sides and a drain counter.
//   state    | meaning
//   ST_EMPTY | no data buffered
//   ST_ONE   | main register holds the head entry
//   ST_TWO   | main holds head, skid holds the next entry
module keyword_skid_chan
  import keyword_skid_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               always_enable,
  input  logic               module_select,
  input  logic               input_valid,
  output logic               input_ready,
  input  logic [WIDTH-1:0]   input_data,
  output logic               output_valid,
  input  logic               output_ready,
  output logic [WIDTH-1:0]   output_data,
  output logic [COUNT_W-1:0] reg_count,
  output logic               is_empty
);

  slice_state_e       state_q;
  slice_state_e       state_d;
  logic [WIDTH-1:0]   main_q;
  logic [WIDTH-1:0]   skid_q;
  logic [COUNT_W-1:0] count_q;
  logic               accept;
  logic               drain;
  logic               load_main_in;
  logic               load_main_skid;
  logic               load_skid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !drain) begin
          state_d = ST_TWO;
        end else if (!accept && drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO:   if (drain) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Reset gates the handshakes so in-flight data is neither taken nor presented.
  always_comb begin
    input_ready    = !reset && always_enable && module_select && (state_q != ST_TWO);
    output_valid   = !reset && always_enable && (state_q != ST_EMPTY);
    accept         = input_valid && input_ready;
    drain          = output_valid && output_ready;
    load_main_in   = accept && ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && drain));
    load_main_skid = drain && (state_q == ST_TWO);
    load_skid      = accept && !drain && (state_q == ST_ONE);
    is_empty       = reset || (state_q == ST_EMPTY);
    output_data    = main_q;
    reg_count      = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q  <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= input_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= input_data;
      end
      if (drain) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keyword_skid_slice.sv
// CHANNELS independent registered skid slices plus an all-channels-idle flag.
module keyword_skid_slice
  import keyword_skid_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int COUNT_W  = DEF_COUNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  keyword_skid_slice_if.slave  bus
);

  logic [CHANNELS-1:0]         ready_vec;
  logic [CHANNELS-1:0]         valid_vec;
  logic [CHANNELS*WIDTH-1:0]   data_vec;
  logic [CHANNELS*COUNT_W-1:0] count_vec;
  logic [CHANNELS-1:0]         empty_vec;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    keyword_skid_chan #(
      .WIDTH   (WIDTH),
      .COUNT_W (COUNT_W)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .always_enable (bus.always_enable),
      .module_select (bus.module_select[c]),
      .input_valid   (bus.input_valid[c]),
      .input_ready   (ready_vec[c]),
      .input_data    (bus.input_data[c*WIDTH +: WIDTH]),
      .output_valid  (valid_vec[c]),
      .output_ready  (bus.output_ready[c]),
      .output_data   (data_vec[c*WIDTH +: WIDTH]),
      .reg_count     (count_vec[c*COUNT_W +: COUNT_W]),
      .is_empty      (empty_vec[c])
    );
  end

  assign bus.input_ready    = ready_vec;
  assign bus.output_valid   = valid_vec;
  assign bus.output_data    = data_vec;
  assign bus.reg_count      = count_vec;
  assign bus.endmodule_flag = &empty_vec;

endmodule
